motoro3_line_calc_param_seq: RTL and testbench

MOTORO3_LINE_CALC_PARAM_SEQ -- requirements
Module: motoro3_line_calc_param_seq

---
 rtl/motoro3_line_calc_param_seq.sv | 146 ++++++++++++++
 tb/tb_motoro3_line_calc_param_seq.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motoro3_line_calc_param_seq.sv
// motoro3_line_calc_param_seq
// Sweeps every step of a sine-length table. Each step's length is scaled by the
// requested full-scale PWM length and saturated to it. The result is handed out
// with a valid/ready handshake.
// Optional feature: define MOTORO3_LCP_MINCLAMP_EN to clamp every result up to
// the latched minimum PWM length (pwmMinMask). Without it pwmMinMask is ignored.
module motoro3_line_calc_param_seq #(
  parameter int PWM_W  = 12,
  parameter int LEN_W  = 16,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              start,
  input  logic [PWM_W-1:0]  pwmLenWant,
  input  logic [PWM_W-1:0]  pwmMinMask,
  output logic [STEP_W-1:0] slAddr,
  input  logic [LEN_W-1:0]  slData,
  output logic [PWM_W-1:0]  plLen,
  output logic [STEP_W-1:0] lcStepOut,
  output logic              plValid,
  input  logic              plReady,
  output logic              busy,
  output logic              done
);

  localparam int PROD_W = PWM_W + LEN_W;
  localparam logic [STEP_W-1:0] LAST_STEP = '1;
  localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MUL,
    OUT,
    DONE
  } state_t;

  state_t            r_state;
  logic [PWM_W-1:0]  r_want;
  logic [PWM_W-1:0]  r_min;
  logic [STEP_W-1:0] r_step;
  logic [PWM_W-1:0]  r_pl_len;
  logic [STEP_W-1:0] r_lc_step;
  logic              r_pl_valid;
  logic              r_busy;
  logic              r_done;

  logic [PROD_W-1:0] w_prod;
  logic [PROD_W-1:0] w_scaled;
  logic [PWM_W-1:0]  w_sat;
  logic [PWM_W-1:0]  w_result;

  // Scale the table word (2**(LEN_W-1) is unity gain), saturate to the
  // requested length and optionally clamp up to the minimum length.
  always_comb begin
    w_prod   = {{LEN_W{1'b0}}, r_want} * {{PWM_W{1'b0}}, slData};
    w_scaled = w_prod >> (LEN_W - 1);
    if (w_scaled > {{LEN_W{1'b0}}, r_want}) begin
      w_sat = r_want;
    end else begin
      w_sat = w_scaled[PWM_W-1:0];
    end
`ifdef MOTORO3_LCP_MINCLAMP_EN
    w_result = (w_sat < r_min) ? r_min : w_sat;
`else
    w_result = w_sat;
`endif
  end

`ifndef MOTORO3_LCP_MINCLAMP_EN
  // The minimum length is still latched so that every build resets and holds
  // the same state, but no logic reads it when the clamp is absent.
  logic w_min_unused;
  assign w_min_unused = ^r_min;
`endif

  // Sequencer: latch operands, then for each step read the table, scale, and
  // hold the result until the consumer accepts it.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state    <= IDLE;
      r_want     <= '0;
      r_min      <= '0;
      r_step     <= '0;
      r_pl_len   <= '0;
      r_lc_step  <= '0;
      r_pl_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_want  <= pwmLenWant;
            r_min   <= pwmMinMask;
            r_step  <= '0;
            r_busy  <= 1'b1;
            r_state <= RD;
          end
        end
        // The table address is r_step itself. Its data arrives in MUL.
        RD: begin
          r_state <= MUL;
        end
        // The scaled result is registered directly, so it is valid on entry to OUT.
        MUL: begin
          r_pl_len   <= w_result;
          r_lc_step  <= r_step;
          r_pl_valid <= 1'b1;
          r_state    <= OUT;
        end
        OUT: begin
          if (plReady) begin
            r_pl_valid <= 1'b0;
            if (r_step == LAST_STEP) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_step  <= r_step + STEP_ONE;
              r_state <= RD;
            end
          end
        end
        // A start seen here is dropped; only IDLE accepts a new sweep.
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign slAddr    = r_step;
  assign plLen     = r_pl_len;
  assign lcStepOut = r_lc_step;
  assign plValid   = r_pl_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_motoro3_line_calc_param_seq.sv
// Testbench for motoro3_line_calc_param_seq.
// The reference model computes floor(want*data/2**(LEN_W-1)) and caps it at
// want. When MOTORO3_LCP_MINCLAMP_EN is defined, it also raises the result to
// the minimum length.
module tb_motoro3_line_calc_param_seq;
  localparam int PWM_W = 12, LEN_W = 16, STEP_W = 4, N = 16;
`ifdef MOTORO3_LCP_MINCLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic clk = 1'b0, nRst = 1'b1, start = 1'b0, plReady = 1'b1;
  logic [PWM_W-1:0] pwmLenWant = '0, pwmMinMask = '0;
  logic [STEP_W-1:0] slAddr, lcStepOut;
  logic [LEN_W-1:0]  slData;
  logic [PWM_W-1:0]  plLen;
  logic plValid, busy, done;

  logic [LEN_W-1:0] tbl [N];
  int total = 0, bad = 0;
  int cyc = 0, start_edge = 0, first_valid_edge = -1, done_edge = -1, n_done = 0;
  int res_len[$], res_step[$], stall_len[$], stall_step[$];

  motoro3_line_calc_param_seq #(.PWM_W(PWM_W), .LEN_W(LEN_W), .STEP_W(STEP_W)) dut (
    .clk(clk), .nRst(nRst), .start(start), .pwmLenWant(pwmLenWant), .pwmMinMask(pwmMinMask),
    .slAddr(slAddr), .slData(slData), .plLen(plLen), .lcStepOut(lcStepOut),
    .plValid(plValid), .plReady(plReady), .busy(busy), .done(done));

  always #5 clk = ~clk;

  // Table memory: data is valid one cycle after the address.
  always @(posedge clk) slData <= tbl[slAddr];

  // Observer: records accepted results, latency markers and done pulses.
  always @(posedge clk) begin
    cyc++;
    if (nRst) begin
      if (start && !busy) start_edge = cyc;
      if (plValid && first_valid_edge < 0) first_valid_edge = cyc;
      if (plValid && plReady) begin
        res_len.push_back(int'(plLen));
        res_step.push_back(int'(lcStepOut));
      end
      if (done) begin
        n_done++;
        done_edge = cyc;
      end
    end
  end

  function automatic int model(int want, int mask, int d);
    longint s;
    s = (longint'(want) * longint'(d)) / (longint'(1) << (LEN_W - 1));
    if (s > want) s = want;
    if (CLAMP && s < mask) s = mask;
    return int'(s);
  endfunction

  task automatic clear_obs();
    res_len.delete(); res_step.delete(); stall_len.delete(); stall_step.delete();
    first_valid_edge = -1; done_edge = -1; n_done = 0;
  endtask

  // Stimulus driver for one sweep. The ready mode sets plReady's behaviour:
  // 0 = always high, 1 = random, 2 = low for 5 cycles at step 3,
  // 3 = always high with start re-pulsed during the done pulse.
  // restart_step and abort_step set where start or reset is injected (-1 means none).
  task automatic run_sweep(input int want, input int mask, input int mode,
                           input int restart_step, input int abort_step, output bit timed_out);
    bit restarted = 1'b0;
    int stall_left = 5;
    int done0;
    done0 = n_done;
    timed_out = 1'b1;
    pwmLenWant = PWM_W'(want); pwmMinMask = PWM_W'(mask); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pwmLenWant = PWM_W'($urandom); pwmMinMask = PWM_W'($urandom);
    for (int n = 0; n < 1000; n++) begin
      start = 1'b0;
      if (abort_step >= 0 && plValid && int'(lcStepOut) == abort_step) begin
        nRst = 1'b0;
        timed_out = 1'b0;
        return;
      end
      if (restart_step >= 0 && !restarted && plValid && int'(lcStepOut) == restart_step) begin
        start = 1'b1; pwmLenWant = 12'd2000; restarted = 1'b1;
      end
      case (mode)
        0: plReady = 1'b1;
        1: plReady = ($urandom_range(0, 1) == 1);
        2: begin
          if (plValid && lcStepOut == 4'd3 && stall_left > 0) begin
            plReady = 1'b0; stall_left--;
            stall_len.push_back(int'(plLen)); stall_step.push_back(int'(lcStepOut));
          end else plReady = 1'b1;
        end
        default: begin
          plReady = 1'b1;
          if (done) start = 1'b1;
        end
      endcase
      @(negedge clk);
      if (n_done != done0) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0; plReady = 1'b1;
  endtask

  task automatic test_reset();
    #1 nRst = 1'b0;
    #12;
    total++;
    if (plLen !== 0 || plValid !== 0 || busy !== 0 || done !== 0 || slAddr !== 0 || lcStepOut !== 0) begin
      bad++;
      $display("FAIL reset_outputs: got len=%0d valid=%0b busy=%0b done=%0b addr=%0d step=%0d want all 0",
               plLen, plValid, busy, done, slAddr, lcStepOut);
    end
    @(negedge clk); nRst = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 0 || plValid !== 0) begin
      bad++; $display("FAIL reset_release_idle: got busy=%0b valid=%0b want 0 0", busy, plValid);
    end
  endtask

  task automatic test_full_scale();
    bit to;
    for (int i = 0; i < N; i++) tbl[i] = 16'd32768;
    clear_obs();
    run_sweep(1000, 0, 0, -1, -1, to);
    repeat (3) @(negedge clk);
    total++; if (to) begin bad++; $display("FAIL full_scale timeout: no done within budget"); end
    total++; if (res_len.size() != N) begin bad++; $display("FAIL full_scale count: got %0d want %0d", res_len.size(), N); end
    for (int i = 0; i < res_len.size() && i < N; i++) begin
      total++; if (res_step[i] != i) begin bad++; $display("FAIL full_scale step[%0d]: got %0d want %0d", i, res_step[i], i); end
      total++; if (res_len[i] != 1000) begin bad++; $display("FAIL full_scale len[%0d]: got %0d want 1000", i, res_len[i]); end
    end
    total++; if (n_done != 1) begin bad++; $display("FAIL full_scale done_pulses: got %0d want 1", n_done); end
    // plValid rises after edge start+2 and is first sampled at edge start+3.
    total++; if (first_valid_edge - start_edge != 3) begin bad++; $display("FAIL first_latency: got %0d want 3", first_valid_edge - start_edge); end
    // done rises after edge start+48 and is first sampled at edge start+49.
    total++; if (done_edge - start_edge != 49) begin bad++; $display("FAIL done_latency: got %0d want 49", done_edge - start_edge); end
    $display("full_scale: results=%0d done_at=%0d", res_len.size(), done_edge - start_edge);
  endtask

  task automatic test_scale_sat();
    bit to;
    for (int i = 0; i < N; i++) tbl[i] = (i % 2 == 0) ? 16'd16384 : 16'd65535;
    clear_obs();
    run_sweep(1000, 0, 0, -1, -1, to);
    total++; if (to || res_len.size() != N) begin bad++; $display("FAIL scale_sat count: got %0d want %0d", res_len.size(), N); end
    for (int i = 0; i < res_len.size() && i < N; i++) begin
      total++;
      if (res_len[i] != ((i % 2 == 0) ? 500 : 1000)) begin
        bad++; $display("FAIL scale_sat len[%0d]: got %0d want %0d", i, res_len[i], (i % 2 == 0) ? 500 : 1000);
      end
    end
    $display("scale_sat: results=%0d", res_len.size());
  endtask

  task automatic test_min_clamp();
    bit to;
    for (int i = 0; i < N; i++) tbl[i] = 16'd1000;
    clear_obs();
    run_sweep(1000, 100, 0, -1, -1, to);
    total++; if (to || res_len.size() != N) begin bad++; $display("FAIL min_clamp count: got %0d want %0d", res_len.size(), N); end
    for (int i = 0; i < res_len.size() && i < N; i++) begin
      total++;
      if (res_len[i] != (CLAMP ? 100 : 30)) begin
        bad++; $display("FAIL min_clamp len[%0d]: got %0d want %0d", i, res_len[i], CLAMP ? 100 : 30);
      end
    end
    $display("min_clamp: clamp=%0b results=%0d", CLAMP, res_len.size());
  endtask

  task automatic test_zero_want();
    bit to;
    int mask;
    mask = int'($urandom_range(1, 4095));
    for (int i = 0; i < N; i++) tbl[i] = LEN_W'($urandom);
    clear_obs();
    run_sweep(0, mask, 0, -1, -1, to);
    total++; if (to || res_len.size() != N) begin bad++; $display("FAIL zero_want count: got %0d want %0d", res_len.size(), N); end
    for (int i = 0; i < res_len.size() && i < N; i++) begin
      total++;
      if (res_len[i] != (CLAMP ? mask : 0)) begin
        bad++; $display("FAIL zero_want len[%0d]: got %0d want %0d", i, res_len[i], CLAMP ? mask : 0);
      end
    end
    $display("zero_want: results=%0d", res_len.size());
  endtask

  task automatic test_random();
    bit to;
    int want, mask;
    for (int r = 0; r < 4; r++) begin
      want = int'($urandom_range(0, 4095)); mask = int'($urandom_range(0, 4095));
      for (int i = 0; i < N; i++) tbl[i] = LEN_W'($urandom);
      clear_obs();
      run_sweep(want, mask, 1, -1, -1, to);
      total++; if (to || res_len.size() != N) begin bad++; $display("FAIL random%0d count: got %0d want %0d", r, res_len.size(), N); end
      for (int i = 0; i < res_len.size() && i < N; i++) begin
        total++; if (res_step[i] != i) begin bad++; $display("FAIL random%0d step[%0d]: got %0d want %0d", r, i, res_step[i], i); end
        total++;
        if (res_len[i] != model(want, mask, int'(tbl[i]))) begin
          bad++; $display("FAIL random%0d len[%0d]: got %0d want %0d", r, i, res_len[i], model(want, mask, int'(tbl[i])));
        end
      end
      $display("random%0d: want=%0d mask=%0d results=%0d", r, want, mask, res_len.size());
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int want;
    want = int'($urandom_range(1, 4095));
    for (int i = 0; i < N; i++) tbl[i] = LEN_W'($urandom);
    clear_obs();
    run_sweep(want, 0, 2, -1, -1, to);
    total++; if (stall_len.size() != 5) begin bad++; $display("FAIL stall_cycles: got %0d want 5", stall_len.size()); end
    for (int k = 0; k < stall_len.size(); k++) begin
      total++;
      if (stall_step[k] != 3 || stall_len[k] != model(want, 0, int'(tbl[3]))) begin
        bad++; $display("FAIL stall_hold[%0d]: got step=%0d len=%0d want step=3 len=%0d", k, stall_step[k], stall_len[k], model(want, 0, int'(tbl[3])));
      end
    end
    total++; if (to || res_len.size() != N) begin bad++; $display("FAIL backpressure count: got %0d want %0d", res_len.size(), N); end
    for (int i = 0; i < res_len.size() && i < N; i++) begin
      total++;
      if (res_step[i] != i || res_len[i] != model(want, 0, int'(tbl[i]))) begin
        bad++; $display("FAIL backpressure [%0d]: got step=%0d len=%0d want step=%0d len=%0d", i, res_step[i], res_len[i], i, model(want, 0, int'(tbl[i])));
      end
    end
    $display("backpressure: want=%0d results=%0d", want, res_len.size());
  endtask

  task automatic test_restart_ignored();
    bit to;
    for (int i = 0; i < N; i++) tbl[i] = LEN_W'($urandom);
    clear_obs();
    run_sweep(1000, 0, 0, 7, -1, to);
    total++; if (to || res_len.size() != N) begin bad++; $display("FAIL restart count: got %0d want %0d", res_len.size(), N); end
    for (int i = 0; i < res_len.size() && i < N; i++) begin
      total++;
      if (res_step[i] != i || res_len[i] != model(1000, 0, int'(tbl[i]))) begin
        bad++; $display("FAIL restart [%0d]: got step=%0d len=%0d want step=%0d len=%0d", i, res_step[i], res_len[i], i, model(1000, 0, int'(tbl[i])));
      end
    end
    $display("restart_ignored: results=%0d", res_len.size());
  endtask

  task automatic test_reset_midsweep();
    bit to;
    int nd;
    for (int i = 0; i < N; i++) tbl[i] = LEN_W'($urandom);
    clear_obs();
    run_sweep(1000, 0, 0, -1, 5, to);
    #1;
    total++; if (to) begin bad++; $display("FAIL abort timeout: step 5 never reached"); end
    total++;
    if (plLen !== 0 || plValid !== 0 || busy !== 0 || done !== 0 || slAddr !== 0 || lcStepOut !== 0) begin
      bad++;
      $display("FAIL abort_outputs: got len=%0d valid=%0b busy=%0b done=%0b addr=%0d step=%0d want all 0",
               plLen, plValid, busy, done, slAddr, lcStepOut);
    end
    nd = n_done;
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 0 || n_done != nd) begin bad++; $display("FAIL abort_idle: got busy=%0b done_pulses=%0d want 0 %0d", busy, n_done, nd); end
    clear_obs();
    run_sweep(700, 0, 0, -1, -1, to);
    total++; if (to || res_len.size() != N) begin bad++; $display("FAIL after_abort count: got %0d want %0d", res_len.size(), N); end
    for (int i = 0; i < res_len.size() && i < N; i++) begin
      total++;
      if (res_step[i] != i || res_len[i] != model(700, 0, int'(tbl[i]))) begin
        bad++; $display("FAIL after_abort [%0d]: got step=%0d len=%0d want step=%0d len=%0d", i, res_step[i], res_len[i], i, model(700, 0, int'(tbl[i])));
      end
    end
    $display("reset_midsweep: results_after=%0d", res_len.size());
  endtask

  task automatic test_back_to_back();
    bit to;
    for (int i = 0; i < N; i++) tbl[i] = LEN_W'($urandom);
    clear_obs();
    run_sweep(1234, 0, 3, -1, -1, to);
    total++; if (to) begin bad++; $display("FAIL b2b timeout: no done within budget"); end
    total++; if (busy !== 0) begin bad++; $display("FAIL start_in_done: got busy=%0b want 0", busy); end
    repeat (2) @(negedge clk);
    total++; if (busy !== 0 || res_len.size() != N) begin bad++; $display("FAIL start_in_done_idle: got busy=%0b results=%0d want 0 %0d", busy, res_len.size(), N); end
    clear_obs();
    run_sweep(3000, 0, 0, -1, -1, to);
    total++; if (to || res_len.size() != N) begin bad++; $display("FAIL b2b count: got %0d want %0d", res_len.size(), N); end
    for (int i = 0; i < res_len.size() && i < N; i++) begin
      total++;
      if (res_len[i] != model(3000, 0, int'(tbl[i]))) begin
        bad++; $display("FAIL b2b len[%0d]: got %0d want %0d", i, res_len[i], model(3000, 0, int'(tbl[i])));
      end
    end
    $display("back_to_back: results=%0d", res_len.size());
  endtask

  initial begin
    for (int i = 0; i < N; i++) tbl[i] = '0;
    test_reset();
    test_full_scale();
    test_scale_sat();
    test_min_clamp();
    test_zero_want();
    test_random();
    test_backpressure();
    test_restart_ignored();
    test_reset_midsweep();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
